// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forward-select codes, FSM states and the
// per-stage control tag carried alongside each instruction.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic valid;
        logic rw;
        logic m2r;
        logic mw;
    } tag_ctrl_t;

    localparam tag_ctrl_t TAG_NOP = '0;

    // MEM outranks WB because it holds the younger write to the same register.
    function automatic logic [1:0] fwd_select(input logic src_is_x0,
                                              input logic mem_hit,
                                              input logic wb_hit);
        if (src_is_x0)
            return FWD_RF;
        else if (mem_hit)
            return FWD_MEM;
        else if (wb_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shadow copy of the EX/MEM/WB pipeline registers, holding only the register
// tags and control bits the hazard logic needs.
module hazard_tag_pipe
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] rs1_id_i,
    input  logic [REG_AW-1:0] rs2_id_i,
    input  logic [REG_AW-1:0] rd_id_i,
    input  logic              regwrite_id_i,
    input  logic              memtoreg_id_i,
    input  logic              memwrite_id_i,
    input  logic              stall_ex_i,
    input  logic              bubble_ex_i,
    input  logic              stall_mem_i,
    input  logic              bubble_wb_i,
    output logic              ex_valid_o,
    output logic              ex_rw_o,
    output logic              ex_m2r_o,
    output logic [REG_AW-1:0] ex_rs1_o,
    output logic [REG_AW-1:0] ex_rs2_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output tag_ctrl_t         mem_ctrl_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic              wb_valid_o,
    output logic              wb_rw_o,
    output logic [REG_AW-1:0] wb_rd_o
);

    tag_ctrl_t         ex_ctrl_q;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    tag_ctrl_t         mem_ctrl_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              wb_valid_q, wb_rw_q;
    logic [REG_AW-1:0] wb_rd_q;

    // A bubble clears the register fields too so a dead slot can never match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q <= TAG_NOP;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_rd_q   <= '0;
        end else if (bubble_ex_i) begin
            ex_ctrl_q <= TAG_NOP;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_rd_q   <= '0;
        end else if (!stall_ex_i) begin
            ex_ctrl_q <= '{valid: id_valid_i, rw: regwrite_id_i,
                           m2r: memtoreg_id_i, mw: memwrite_id_i};
            ex_rs1_q  <= rs1_id_i;
            ex_rs2_q  <= rs2_id_i;
            ex_rd_q   <= rd_id_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ctrl_q <= TAG_NOP;
            mem_rd_q   <= '0;
        end else if (!stall_mem_i) begin
            mem_ctrl_q <= ex_ctrl_q;
            mem_rd_q   <= ex_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= '0;
        end else if (bubble_wb_i) begin
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            wb_valid_q <= mem_ctrl_q.valid;
            wb_rw_q    <= mem_ctrl_q.rw;
            wb_rd_q    <= mem_rd_q;
        end
    end

    assign ex_valid_o = ex_ctrl_q.valid;
    assign ex_rw_o    = ex_ctrl_q.rw;
    assign ex_m2r_o   = ex_ctrl_q.m2r;
    assign ex_rs1_o   = ex_rs1_q;
    assign ex_rs2_o   = ex_rs2_q;
    assign ex_rd_o    = ex_rd_q;
    assign mem_ctrl_o = mem_ctrl_q;
    assign mem_rd_o   = mem_rd_q;
    assign wb_valid_o = wb_valid_q;
    assign wb_rw_o    = wb_rw_q;
    assign wb_rd_o    = wb_rd_q;

endmodule

// File: rtl/hazard_unit.sv
// Forwarding selects, load-use bubbles and data-memory wait stalls for the
// 5-stage pipeline. Define HAZARD_PERF_EN to add saturating stall counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              regwrite_id,
    input  logic              memtoreg_id,
    input  logic              memwrite_id,
    input  logic              mem_ready,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              bubble_ex,
    output logic              bubble_wb
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       lu_stall_cnt,
    output logic [31:0]       mem_stall_cnt
`endif
);

    logic              ex_valid, ex_rw, ex_m2r;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    tag_ctrl_t         mem_ctrl;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_valid, wb_rw;
    logic [REG_AW-1:0] wb_rd;

    hazard_tag_pipe #(.REG_AW(REG_AW)) u_tags (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid_i    (id_valid),
        .rs1_id_i      (rs1_id),
        .rs2_id_i      (rs2_id),
        .rd_id_i       (rd_id),
        .regwrite_id_i (regwrite_id),
        .memtoreg_id_i (memtoreg_id),
        .memwrite_id_i (memwrite_id),
        .stall_ex_i    (stall_ex),
        .bubble_ex_i   (bubble_ex),
        .stall_mem_i   (stall_mem),
        .bubble_wb_i   (bubble_wb),
        .ex_valid_o    (ex_valid),
        .ex_rw_o       (ex_rw),
        .ex_m2r_o      (ex_m2r),
        .ex_rs1_o      (ex_rs1),
        .ex_rs2_o      (ex_rs2),
        .ex_rd_o       (ex_rd),
        .mem_ctrl_o    (mem_ctrl),
        .mem_rd_o      (mem_rd),
        .wb_valid_o    (wb_valid),
        .wb_rw_o       (wb_rw),
        .wb_rd_o       (wb_rd)
    );

    logic ex_eff, mem_eff, wb_eff;
    logic load_use_raw, load_use, mem_wait;
    hz_state_t state_q, state_d;

    assign ex_eff  = ex_valid & ex_rw & (ex_rd != '0);
    assign mem_eff = mem_ctrl.valid & mem_ctrl.rw & (mem_rd != '0);
    assign wb_eff  = wb_valid & wb_rw & (wb_rd != '0);

    // A load in MEM has no data yet, so it is never a MEM-stage forward source.
    assign fwd_a = fwd_select(ex_rs1 == '0,
                              mem_eff & ~mem_ctrl.m2r & (mem_rd == ex_rs1),
                              wb_eff & (wb_rd == ex_rs1));
    assign fwd_b = fwd_select(ex_rs2 == '0,
                              mem_eff & ~mem_ctrl.m2r & (mem_rd == ex_rs2),
                              wb_eff & (wb_rd == ex_rs2));

    assign load_use_raw = ex_eff & ex_m2r & id_valid &
                          (((rs1_id != '0) & (rs1_id == ex_rd)) |
                           ((rs2_id != '0) & (rs2_id == ex_rd)));
    // After a load-use bubble the load has moved on, so EX cannot re-trigger.
    assign load_use = load_use_raw & (state_q != LU_STALL);
    assign mem_wait = mem_ctrl.valid & (mem_ctrl.m2r | mem_ctrl.mw) & ~mem_ready;

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        bubble_ex = 1'b0;
        bubble_wb = 1'b0;
        state_d   = RUN;
        if (mem_wait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
            state_d   = MEM_WAIT;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = LU_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] lu_cnt_q, mem_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            if (bubble_ex && (lu_cnt_q != 32'hFFFF_FFFF))
                lu_cnt_q <= lu_cnt_q + 32'd1;
            if (mem_wait && (mem_cnt_q != 32'hFFFF_FFFF))
                mem_cnt_q <= mem_cnt_q + 32'd1;
        end
    end

    assign lu_stall_cnt  = lu_cnt_q;
    assign mem_stall_cnt = mem_cnt_q;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Generates the control side of operand forwarding for the 5-stage RISC-V pipeline: per-operand forward selects for the EX-stage forwarding mux, load-use bubble insertion and data-memory wait stalls. Internally tracks destination/source register tags as instructions move ID→EX→MEM→WB, so the datapath only supplies ID-stage decode fields and a memory-ready handshake. Sits beside the decoder, driving the IF/ID/EX/MEM pipeline-register enables and the forwarding mux selects.

## Interface
- REG_AW, 5, register-index width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- rs1_id, rs2_id  in  REG_AW  source registers of ID instruction (ignore when 0)
- rd_id  in  REG_AW  destination register of ID instruction
- regwrite_id  in  1  ID instruction writes rd
- memtoreg_id  in  1  ID instruction is a load
- memwrite_id  in  1  ID instruction is a store
- mem_ready  in  1  data memory completes the MEM-stage access this cycle
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM ALU result, 10 WB result, 11 never driven
- stall_if, stall_id  out  1  hold PC and IF/ID register
- stall_ex, stall_mem  out  1  hold ID/EX and EX/MEM registers
- bubble_ex  out  1  load ID/EX with a NOP
- bubble_wb  out  1  load MEM/WB with a NOP

## Operation
- Tag stages (registers): EX {valid, rs1, rs2, rd, rw, m2r, mw}; MEM {valid, rd, rw, m2r, mw}; WB {valid, rd, rw}.
- Advance: each enabled stage copies its predecessor on clk; bubble loads valid=0, rw=0, m2r=0, mw=0.
- Effective write: stage valid & rw & rd≠0.
- Forwarding (operand A; B identical with rs2): MEM effective write, m2r_mem=0, rd_mem==rs1_ex → 01; else WB effective write, rd_wb==rs1_ex → 10; else 00. MEM beats WB. rs1_ex==0 → 00.
- Load-use hazard: EX effective write with m2r_ex=1, id_valid=1, rd_ex equals nonzero rs1_id or rs2_id.
- Memory wait: MEM valid & (m2r_mem | mw_mem) & !mem_ready.
- FSM states RUN, LU_STALL, MEM_WAIT (registered); outputs Mealy on state, tags, inputs:
  - Memory wait (any state) → stall_if/id/ex/mem=1, bubble_wb=1, bubble_ex=0; next state MEM_WAIT.
  - Else load-use → stall_if/id=1, bubble_ex=1, EX→MEM→WB advance; next state LU_STALL.
  - Else all stalls/bubbles 0; next state RUN.
  - LU_STALL cannot repeat for the same load: the load has left EX.
- Memory wait has priority over load-use; a load-use detected during MEM_WAIT is re-evaluated after release.
- Forward selects remain valid while stalled (tags frozen).

## Timing
- Reset (async, immediate): all tag valid/rw/m2r/mw=0, state RUN; fwd_a/fwd_b=00, all stall/bubble outputs 0. Holds until first clk edge after rst_n rises.
- fwd_a/fwd_b: zero latency, combinational from EX/MEM/WB tags, valid the cycle the consumer is in EX.
- Load-use: exactly 1 bubble; consumer reaches EX with the load in WB, fwd=10.
- MEM_WAIT: stall lasts each cycle mem_ready=0; pipeline advances on the first edge with mem_ready=1 (zero-wait access adds no cycles).
- Reset asserted mid-stall: stall deasserts immediately; no recovery of frozen instructions required.

## Configuration
- HAZARD_PERF_EN defined: adds outputs lu_stall_cnt (32) and mem_stall_cnt (32), increment once per cycle in load-use / memory-wait condition respectively, saturate at 0xFFFF_FFFF, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- hazard_pkg: fwd select constants (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10), FSM state enum, tag struct/typedef.
- Sub-module hazard_tag_pipe: EX/MEM/WB tag registers with per-stage enable/bubble; hazard_unit holds comparators, FSM, counters.

## Test plan
- Reset: rst_n=0 mid-stream with stall active → all outputs 0 same cycle, fwd=00 after release.
- add x5 then add x6,x5,x1 back-to-back → consumer in EX: fwd_a=01; one instruction gap → fwd_a=10; rd=x0 producer → fwd=00.
- x7 written by both MEM and WB instructions, consumer reads x7 on both operands → fwd_a=fwd_b=01.
- lw x8 then add x9,x8,x8 → one cycle stall_if=stall_id=bubble_ex=1, next cycle consumer in EX with fwd_a=fwd_b=10, no further stall.
- lw in MEM with mem_ready low 3 cycles → stall_if/id/ex/mem=1 and bubble_wb=1 for exactly 3 cycles, release on 4th; with HAZARD_PERF_EN mem_stall_cnt=3.
- lw x8 in EX with consumer in ID while older store in MEM waits (mem_ready=0) → MEM_WAIT outputs only; after release, one load-use bubble.
